// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave state encoding and acknowledge bit values.
`timescale 1ns/1ps

package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } slave_state_t;

    // Level on sda during the ninth clock of a byte.
    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings scl/sda into the clk domain and flags scl edges plus START/STOP.
`timescale 1ns/1ps

module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    // Synchronizer chains plus one extra stage for edge detection; all reset
    // to the idle-bus level so reset release never looks like a START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the value
            // from before this edge, so the chain shifts one stage per clock.
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    // sda may only move while scl is low, except for START and STOP.
    assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave: 7-bit addressing, unlimited-length writes and reads, no clock
// stretching. sda is open-drain (drives 0 or releases).
`timescale 1ns/1ps

module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'b0010000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       addr_match,
    output logic       master_nack
);

    slave_state_t state, state_nxt;

    logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic       byte_done;

    logic [2:0] bit_cnt, cnt_nxt;
    logic [6:0] rx_shift, rx_shift_nxt;   // bits received so far, MSB first
    logic [6:0] tx_shift, tx_shift_nxt;   // read bits still to be driven
    logic [7:0] rx_data_nxt;
    logic       rw, rw_nxt;
    // ACK states: 0 = waiting for the fall that starts the ACK, 1 = ACK on bus.
    // RD_ACK:     0 = waiting for master's ACK, 1 = ACKed, load on next fall.
    logic       ack_phase, phase_nxt;
    logic       sda_oe, oe_nxt;
    logic       busy_nxt, match_nxt;
    logic       rx_upd, rx_upd_nxt;
    logic       load_nxt, nack_nxt;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Open-drain output; the flop resets asynchronously so sda lets go at once.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    assign byte_done = scl_rise && (bit_cnt == 3'd7);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; START beats everything, then STOP.
    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = ADDR;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR:     if (byte_done)
                              state_nxt = (rx_shift == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall && ack_phase)
                              state_nxt = rw ? RD_DATA : WR_DATA;
                WR_DATA:  if (byte_done) state_nxt = WR_ACK;
                WR_ACK:   if (scl_fall && ack_phase) state_nxt = WR_DATA;
                RD_DATA:  if (byte_done) state_nxt = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && !ack_phase && (sda_s == NACK_BIT))
                        state_nxt = IGNORE;
                    else if (scl_fall && ack_phase)
                        state_nxt = RD_DATA;
                end
                default:  state_nxt = state;
            endcase
        end
    end

    // Output/datapath next values: sampling on scl_rise, sda changes on scl_fall.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        cnt_nxt      = bit_cnt;
        rx_shift_nxt = rx_shift;
        tx_shift_nxt = tx_shift;
        rx_data_nxt  = rx_data;
        rw_nxt       = rw;
        phase_nxt    = ack_phase;
        oe_nxt       = sda_oe;
        busy_nxt     = busy;
        match_nxt    = addr_match;
        rx_upd_nxt   = 1'b0;
        load_nxt     = 1'b0;
        nack_nxt     = 1'b0;

        if (start_det) begin
            cnt_nxt   = 3'd0;
            phase_nxt = 1'b0;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b1;
            match_nxt = 1'b0;
        end else if (stop_det) begin
            cnt_nxt   = 3'd0;
            phase_nxt = 1'b0;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            match_nxt = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        rx_shift_nxt = {rx_shift[5:0], sda_s};
                        cnt_nxt      = bit_cnt + 3'd1;
                        phase_nxt    = 1'b0;
                        if (byte_done && (rx_shift == SLAVE_ADDR)) begin
                            match_nxt = 1'b1;
                            rw_nxt    = sda_s;
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            oe_nxt    = 1'b1;
                            phase_nxt = 1'b1;
                        end else begin
                            oe_nxt    = 1'b0;
                            phase_nxt = 1'b0;
                            cnt_nxt   = 3'd0;
                            if ((state == ADDR_ACK) && rw) begin
                                tx_shift_nxt = tx_data[6:0];
                                oe_nxt       = ~tx_data[7];
                                load_nxt     = 1'b1;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        rx_shift_nxt = {rx_shift[5:0], sda_s};
                        cnt_nxt      = bit_cnt + 3'd1;
                        if (byte_done) begin
                            rx_data_nxt = {rx_shift, sda_s};
                            rx_upd_nxt  = 1'b1;
                            phase_nxt   = 1'b0;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        cnt_nxt = bit_cnt + 3'd1;
                        if (byte_done) phase_nxt = 1'b0;
                    end else if (scl_fall) begin
                        oe_nxt       = ~tx_shift[6];
                        tx_shift_nxt = {tx_shift[5:0], 1'b0};
                    end
                end
                RD_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            oe_nxt = 1'b0;
                        end else begin
                            tx_shift_nxt = tx_data[6:0];
                            oe_nxt       = ~tx_data[7];
                            load_nxt     = 1'b1;
                            phase_nxt    = 1'b0;
                            cnt_nxt      = 3'd0;
                        end
                    end else if (scl_rise && !ack_phase) begin
                        if (sda_s == ACK_BIT) phase_nxt = 1'b1;
                        else                  nack_nxt  = 1'b1;
                    end
                end
                default: begin
                    oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= 3'd0;
            rx_shift    <= 7'd0;
            tx_shift    <= 7'd0;
            rx_data     <= 8'h00;
            rw          <= 1'b0;
            ack_phase   <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            addr_match  <= 1'b0;
            rx_upd      <= 1'b0;
            rx_valid    <= 1'b0;
            tx_load     <= 1'b0;
            master_nack <= 1'b0;
        end else begin
            bit_cnt     <= cnt_nxt;
            rx_shift    <= rx_shift_nxt;
            tx_shift    <= tx_shift_nxt;
            rx_data     <= rx_data_nxt;
            rw          <= rw_nxt;
            ack_phase   <= phase_nxt;
            sda_oe      <= oe_nxt;
            busy        <= busy_nxt;
            addr_match  <= match_nxt;
            rx_upd      <= rx_upd_nxt;
            rx_valid    <= rx_upd;      // one clk after rx_data changes
            tx_load     <= load_nxt;
            master_nack <= nack_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master plus scoreboards for written
// and read bytes, and pulse counters for the strobe outputs.
`timescale 1ns/1ps

module tb_i2c_slave;

    localparam int H = 8;   // clks per scl phase
    localparam int Q = 4;   // clks to quarter point

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_drv;
    logic       m_sda_low;
    logic [7:0] tx_data;
    logic       tx_load, rx_valid, busy, addr_match, master_nack;
    logic [7:0] rx_data;
    wire        sda;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave #(
        .SLAVE_ADDR  (7'b0010000),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl         (scl_drv),
        .sda         (sda),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .addr_match  (addr_match),
        .master_nack (master_nack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboards
    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];
    int n_rxv = 0, n_load = 0, n_nack = 0, n_extra = 0;

    // Written-byte scoreboard and strobe counters, sampled away from posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_load)     n_load++;
            if (master_nack) n_nack++;
            if (rx_valid) begin
                n_rxv++;
                if (exp_rx.size() == 0) n_extra++;
                else check("rx_byte", rx_data, exp_rx.pop_front());
            end
        end
    end

    // Watches for the slave pulling sda low and for busy dropping mid-transfer.
    logic watch_drive = 1'b0, watch_busy = 1'b0;
    int   drove = 0, busy_low = 0;
    always @(negedge clk) begin
        #1;
        if (watch_drive && (sda === 1'b0) && !m_sda_low) drove++;
        if (watch_busy && !busy) busy_low++;
    end

    // Master primitives; each bit starts and ends with scl just fallen.
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b1; wait_clk(H); scl_drv = 1'b0;
    endtask

    task automatic bus_rstart();
        wait_clk(Q); m_sda_low = 1'b0; wait_clk(Q); scl_drv = 1'b1;
        wait_clk(H); m_sda_low = 1'b1; wait_clk(H); scl_drv = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(Q); m_sda_low = 1'b1; wait_clk(Q); scl_drv = 1'b1;
        wait_clk(H); m_sda_low = 1'b0; wait_clk(H);
    endtask

    task automatic write_bit(input logic b);
        wait_clk(Q); m_sda_low = ~b; wait_clk(Q); scl_drv = 1'b1;
        wait_clk(H); scl_drv = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_clk(Q); m_sda_low = 1'b0; wait_clk(Q); scl_drv = 1'b1;
        wait_clk(Q); b = sda; wait_clk(Q); scl_drv = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    // Reads a byte; next_tx is presented before the ack bit so the slave can
    // load it on the following fall when the master ACKs.
    task automatic read_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        tx_data = next_tx;
        write_bit(nack);
    endtask

    task automatic read_and_check(input string tag, input logic nack, input logic [7:0] next_tx);
        logic [7:0] d;
        logic [7:0] e;
        read_byte(nack, next_tx, d);
        e = exp_rd.pop_front();
        check(tag, d, e);
    endtask

    // Global time bound.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic ack;
        int   v0, l0, k0;

        rst_n = 1'b0; scl_drv = 1'b1; m_sda_low = 1'b0; tx_data = 8'h00;
        wait_clk(5);
        check("rst_sda",         sda,         1);
        check("rst_rx_data",     rx_data,     8'h00);
        check("rst_rx_valid",    rx_valid,    0);
        check("rst_tx_load",     tx_load,     0);
        check("rst_busy",        busy,        0);
        check("rst_addr_match",  addr_match,  0);
        check("rst_master_nack", master_nack, 0);
        rst_n = 1'b1;
        wait_clk(5);

        // Single-byte write then STOP
        v0 = n_rxv;
        bus_start();
        check("wr1_busy", busy, 1);
        write_byte(8'h20, ack);
        check("wr1_addr_ack", ack, 0);
        check("wr1_addr_match", addr_match, 1);
        exp_rx.push_back(8'hA5);
        write_byte(8'hA5, ack);
        check("wr1_data_ack", ack, 0);
        bus_stop();
        check("wr1_busy_after_stop", busy, 0);
        check("wr1_match_after_stop", addr_match, 0);
        check("wr1_rx_data", rx_data, 8'hA5);
        check("wr1_rx_valid_cnt", n_rxv - v0, 1);

        // Single-byte read, master NACKs
        l0 = n_load; k0 = n_nack;
        tx_data = 8'h3C; exp_rd.push_back(8'h3C);
        bus_start();
        write_byte(8'h21, ack);
        check("rd1_addr_ack", ack, 0);
        read_and_check("rd1_data", 1'b1, 8'h00);
        bus_stop();
        check("rd1_tx_load_cnt", n_load - l0, 1);
        check("rd1_nack_cnt", n_nack - k0, 1);

        // Wrong address: slave must stay off the bus
        v0 = n_rxv; drove = 0;
        watch_drive = 1'b1;
        bus_start();
        write_byte(8'h22, ack);
        check("bad_addr_nack", ack, 1);
        check("bad_addr_match", addr_match, 0);
        write_byte(8'h5A, ack);
        check("bad_data_nack", ack, 1);
        bus_stop();
        watch_drive = 1'b0;
        check("bad_sda_driven", drove, 0);
        check("bad_rx_valid_cnt", n_rxv - v0, 0);
        check("bad_rx_data_kept", rx_data, 8'hA5);

        // Three-byte write
        v0 = n_rxv;
        bus_start();
        write_byte(8'h20, ack);
        check("wr3_addr_ack", ack, 0);
        foreach (exp_rx[i]) ;
        for (int i = 1; i <= 3; i++) begin
            logic [7:0] b;
            b = 8'(i * 8'h11);
            exp_rx.push_back(b);
            write_byte(b, ack);
            check("wr3_data_ack", ack, 0);
        end
        bus_stop();
        check("wr3_rx_valid_cnt", n_rxv - v0, 3);
        check("wr3_rx_data", rx_data, 8'h33);

        // Two-byte read, ACK then NACK
        l0 = n_load; k0 = n_nack;
        tx_data = 8'h5A; exp_rd.push_back(8'h5A); exp_rd.push_back(8'hC3);
        bus_start();
        write_byte(8'h21, ack);
        check("rd2_addr_ack", ack, 0);
        read_and_check("rd2_byte0", 1'b0, 8'hC3);
        read_and_check("rd2_byte1", 1'b1, 8'h00);
        bus_stop();
        check("rd2_tx_load_cnt", n_load - l0, 2);
        check("rd2_nack_cnt", n_nack - k0, 1);

        // Write, repeated START, read
        bus_start();
        write_byte(8'h20, ack);
        check("rs_wr_addr_ack", ack, 0);
        busy_low = 0; watch_busy = 1'b1;
        exp_rx.push_back(8'h55);
        write_byte(8'h55, ack);
        check("rs_wr_data_ack", ack, 0);
        tx_data = 8'h9C; exp_rd.push_back(8'h9C);
        bus_rstart();
        write_byte(8'h21, ack);
        check("rs_rd_addr_ack", ack, 0);
        check("rs_rd_addr_match", addr_match, 1);
        read_and_check("rs_rd_data", 1'b1, 8'h00);
        watch_busy = 1'b0;
        check("rs_busy_held", busy_low, 0);
        check("rs_rx_data", rx_data, 8'h55);
        bus_stop();

        // Reset during the ACK low phase, then recover
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(1'((8'h20 >> i) & 1));
        m_sda_low = 1'b0;
        wait_clk(Q);
        check("mid_ack_low", sda, 0);
        check("mid_addr_match", addr_match, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sda_released", sda, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr_match", addr_match, 0);
        check("mid_rst_rx_data", rx_data, 8'h00);
        check("mid_rst_strobes", {rx_valid, tx_load, master_nack}, 3'b000);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        scl_drv = 1'b1;
        wait_clk(H);
        check("post_rst_idle_busy", busy, 0);
        bus_start();
        write_byte(8'h20, ack);
        check("post_rst_addr_ack", ack, 0);
        exp_rx.push_back(8'h77);
        write_byte(8'h77, ack);
        check("post_rst_data_ack", ack, 0);
        bus_stop();
        check("post_rst_rx_data", rx_data, 8'h77);

        wait_clk(4);
        check("rx_queue_left", exp_rx.size(), 0);
        check("rd_queue_left", exp_rd.size(), 0);
        check("rx_extra_pulses", n_extra, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'b0010000, is the 7-bit address this slave answers to.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth on scl/sda inputs (legal 2..3).
REQ-003 clk  input  1  system clock; the block uses one clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 scl  input  1  I2C clock from the master, pulled up externally; the slave never drives it (no stretching).
REQ-006 sda  inout  1  I2C data, open-drain; the slave drives only 1'b0 or 1'bz.
REQ-007 tx_data  input  8  byte returned to the master on a read.
REQ-008 tx_load  output  1  1-clk pulse when tx_data is latched into the shift register.
REQ-009 rx_data  output  8  last byte written by the master.
REQ-010 rx_valid  output  1  1-clk pulse when rx_data is updated.
REQ-011 busy  output  1  high from the detected START until the detected STOP.
REQ-012 addr_match  output  1  high while the current transfer is addressed to SLAVE_ADDR.
REQ-013 master_nack  output  1  1-clk pulse when the master NACKs a read byte.

Function
REQ-014 The slave SHALL pass scl/sda through SYNC_STAGES flops, then derive scl_rise, scl_fall, start_det (sda fall while scl high) and stop_det (sda rise while scl high).
REQ-015 The FSM states SHALL be IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-016 start_det in any state SHALL go to ADDR with the bit counter cleared (repeated START supported).
REQ-017 stop_det in any state SHALL go to IDLE, release sda and deassert busy and addr_match.
REQ-018 Data bits SHALL be sampled MSB first on scl_rise; sda SHALL be changed only on scl_fall.
REQ-019 ADDR: after the 8th scl_rise, if bits[7:1]==SLAVE_ADDR the FSM SHALL enter ADDR_ACK, set addr_match and latch rw=bit0; otherwise it SHALL enter IGNORE and never drive sda.
REQ-020 ADDR_ACK: sda SHALL be driven 0 from the next scl_fall until the following scl_fall, then go to WR_DATA (rw=0) or RD_DATA (rw=1).
REQ-021 On entry to RD_DATA, tx_data SHALL be latched with tx_load pulsed in the same cycle, and bit 7 SHALL be driven on that scl_fall.
REQ-022 RD_DATA: a 0 bit SHALL drive sda low, a 1 bit SHALL release it; after 8 bits sda SHALL be released for RD_ACK.
REQ-023 RD_ACK: on scl_rise, sda=0 SHALL return to RD_DATA with the next tx_data; sda=1 SHALL pulse master_nack and go to IGNORE until STOP/START.
REQ-024 WR_DATA: on the 8th scl_rise, rx_data SHALL update and rx_valid SHALL pulse one clk later; the FSM then enters WR_ACK.
REQ-025 WR_ACK SHALL drive ACK as in REQ-020 and return to WR_DATA; the number of bytes per transfer is unlimited.
REQ-026 A bit counter SHALL be 3 bits wide, cleared on START and ACK exit, and wrap 7->0.
REQ-027 Correct operation SHALL require scl high and low phases of at least SYNC_STAGES+2 clk each.
REQ-028 start_det and stop_det in the same cycle cannot occur; scl_rise coinciding with start_det SHALL give start_det priority.

Reset
REQ-029 While rst_n=0, state SHALL be IDLE, sda released (z), rx_data=8'h00, and rx_valid, tx_load, busy, addr_match, master_nack all 0.
REQ-030 Synchronizer flops SHALL reset to 1 (bus idle) so that no false START is seen at deassertion.
REQ-031 Reset mid-transfer SHALL release sda immediately (asynchronously); after deassertion the slave SHALL wait for the next START.

Structure
REQ-032 Package i2c_pkg SHALL hold the slave state enum and the ACK/NACK bit constants, shared with the master.
REQ-033 Sub-module i2c_bus_sync SHALL contain the synchronizers plus edge and START/STOP detection; i2c_slave instantiates it once.

Verification
REQ-034 Write 0x20,0xA5,STOP from i2c_top (addr 7'b0010000, rw=0) -> ACK on both bytes, rx_data=8'hA5, one rx_valid pulse, busy low after STOP.
REQ-035 Read with tx_data=8'h3C, master NACKs -> master data_out=8'h3C, valid_out pulse, one tx_load and one master_nack pulse.
REQ-036 Address 7'b0010001 -> slave never drives sda, addr_match=0, master erro_addr=1.
REQ-037 Write 3 bytes 0x11,0x22,0x33 -> three rx_valid pulses, final rx_data=8'h33.
REQ-038 Write 0x20,0x55 then repeated START, 0x21, read 0x9C -> rx_data=8'h55, then read returns 8'h9C, no IDLE between.
REQ-039 Assert rst_n=0 during the ACK low phase -> sda released within the same clk, all outputs at reset values, next START-addressed write succeeds.
